// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader that assembles little-endian words into instruction memory.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  error
);
  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_END  = S_CSUM;
`else
  localparam logic [2:0] S_END  = S_DONE;
`endif
  localparam logic [16:0] CAP = 17'(2 ** ADDR_WIDTH);

  logic [2:0]            state, state_nxt;
  logic [7:0]            len_lo;
  logic [ADDR_WIDTH:0]   n, word_cnt, word_nxt;
  logic [1:0]            byte_cnt;
  logic [23:0]           acc;
  logic [15:0]           len;
  logic                  accept, restart;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign in_ready = !(state == S_DONE || state == S_ERR);
  assign accept   = in_valid & in_ready;
  assign restart  = reload & ~in_ready;
  assign len      = {in_data, len_lo};
  assign word_nxt = word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_nxt = state;
    if (restart) state_nxt = S_LEN0;
    else if (accept)
      case (state)
        S_LEN0: state_nxt = S_LEN1;
        S_LEN1: state_nxt = ({1'b0, len} > CAP) ? S_ERR : (len == 16'd0) ? S_END : S_DATA;
        S_DATA: state_nxt = (byte_cnt == 2'd3 && word_nxt == n) ? S_END : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: state_nxt = (in_data == csum) ? S_DONE : S_ERR;
`endif
        default: state_nxt = state;
      endcase
  end

  // Status outputs follow the next state so the final write and the core release share a cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_LEN0;
      len_lo     <= '0;
      n          <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      acc        <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      done       <= state_nxt == S_DONE;
      error      <= state_nxt == S_ERR;
      core_rst_n <= state_nxt == S_DONE;
      mem_we     <= 1'b0;
      if (restart) begin
        len_lo   <= '0;
        n        <= '0;
        byte_cnt <= '0;
        word_cnt <= '0;
        acc      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (accept) begin
        if (state == S_LEN0) len_lo <= in_data;
        if (state == S_LEN1) n <= len[ADDR_WIDTH:0];
        if (state == S_DATA) begin
          byte_cnt <= byte_cnt + 2'd1;
          acc      <= {in_data, acc[23:8]};
          if (byte_cnt == 2'd3) begin
            mem_we    <= 1'b1;
            mem_waddr <= word_cnt[ADDR_WIDTH-1:0];
            mem_wdata <= {in_data, acc};
            word_cnt  <= word_nxt;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum + in_data;
`endif
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream stimulus checked every cycle against a byte-position model.
module tb_imem_loader;
  localparam int AW = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  typedef logic [31:0] wq_t[$];

  logic          CLK = 1'b0, RST = 1'b0, in_valid = 1'b0, reload = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready, mem_we, core_rst_n, done, error;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0, wr_cnt = 0;
  bit chk_en = 1'b0, bp = 1'b0, prev_we = 1'b0;
  logic [31:0] dut_mem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Model: tracks the position of each accepted byte in the stream and derives outputs from it.
  bit            m_load = 1'b1, m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [31:0]   m_wdata = '0;
  logic [7:0]    lo = 8'd0, m_sum = 8'd0, b;
  logic [7:0]    wb [4];
  int            pos = 0, m_n = 0, lane;

  always @(posedge CLK) begin
    if (!RST) begin
      m_load = 1'b1; m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
      m_waddr = '0; m_wdata = '0; pos = 0; m_n = 0; m_sum = 8'd0;
    end else begin
      m_we = 1'b0;
      if (!m_load) begin
        if (reload) begin
          m_load = 1'b1; m_done = 1'b0; m_err = 1'b0; pos = 0; m_sum = 8'd0;
        end
      end else if (in_valid) begin
        b = in_data;
        if (pos == 0) lo = b;
        else if (pos == 1) m_n = int'({b, lo});
        else if (pos < 2 + 4 * m_n) begin
          lane = (pos - 2) % 4;
          wb[lane] = b;
          if (lane == 3) begin
            m_we = 1'b1;
            m_waddr = AW'((pos - 2) / 4);
            m_wdata = {wb[3], wb[2], wb[1], wb[0]};
          end
        end else begin
          m_load = 1'b0;
          if (b == m_sum) m_done = 1'b1; else m_err = 1'b1;
        end
        m_sum = m_sum + b;
        pos++;
        if (m_load && pos == 2 && m_n > 64) begin
          m_load = 1'b0; m_err = 1'b1;
        end else if (m_load && !CS && pos == 2 + 4 * m_n) begin
          m_load = 1'b0; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk1("in_ready", in_ready, m_load);
      chk1("done", done, m_done);
      chk1("error", error, m_err);
      chk1("core_rst_n", core_rst_n, m_done);
      chk1("mem_we", mem_we, m_we);
      chk("mem_waddr", {26'd0, mem_waddr}, {26'd0, m_waddr});
      chk("mem_wdata", mem_wdata, m_wdata);
      if (mem_we) begin
        chk1("we_gap", prev_we, 1'b0);
        wr_cnt++;
        dut_mem[mem_waddr] = mem_wdata;
      end
      prev_we = mem_we;
    end
  end

  task automatic send(input logic [7:0] v);
    int t = 0;
    bit ok = 1'b0;
    while (!ok) begin
      @(negedge CLK);
      reload = 1'b0;
      if (bp && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = 8'($urandom);
      end else begin
        in_valid = 1'b1; in_data = v; ok = in_ready;
      end
      t++;
      if (!ok && t > 200) begin
        chk1("send_timeout", 1'b0, 1'b1);
        ok = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_valid = 1'b0; reload = 1'b0; in_data = 8'($urandom);
    end
  endtask

  task automatic reload_pulse(input bit with_valid);
    @(negedge CLK);
    reload = 1'b1; in_valid = with_valid; in_data = 8'($urandom);
    idle(1);
  endtask

  task automatic load(input int n, input wq_t w, input logic [7:0] bad);
    logic [7:0] q[$];
    logic [7:0] s = 8'd0;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    foreach (w[i]) for (int j = 0; j < 4; j++) q.push_back(w[i][8*j +: 8]);
    foreach (q[i]) s = s + q[i];
    if (CS) q.push_back(s ^ bad);
    foreach (q[i]) send(q[i]);
    idle(3);
  endtask

  function automatic wq_t rand_words(input int n);
    wq_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t w;
    int base, n;
    @(posedge CLK);
    @(posedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_core_rst_n", core_rst_n, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_wdata", mem_wdata, 32'h0);
    RST = 1'b1;
    idle(2);

    w.delete(); w.push_back(32'h00100093); w.push_back(32'hFFF08113);
    load(2, w, 8'h00);
    chk("n2_writes", wr_cnt, 32'd2);
    chk("n2_addr0", dut_mem[0], 32'h00100093);
    chk("n2_addr1", dut_mem[1], 32'hFFF08113);
    chk1("n2_done", done, 1'b1);
    chk1("n2_core_rst_n", core_rst_n, 1'b1);

    reload_pulse(1'b1);
    chk1("reload_in_ready", in_ready, 1'b1);
    chk1("reload_done", done, 1'b0);
    chk1("reload_core_rst_n", core_rst_n, 1'b0);

    bp = 1'b1;
    base = wr_cnt;
    load(3, rand_words(3), 8'h00);
    chk("bp_writes", wr_cnt - base, 32'd3);
    reload_pulse(1'b0);

    base = wr_cnt;
    send(8'h41); send(8'h00); idle(3);
    chk1("len65_error", error, 1'b1);
    chk1("len65_in_ready", in_ready, 1'b0);
    chk("len65_writes", wr_cnt - base, 32'd0);
    reload_pulse(1'b0);
    chk1("len65_reload_error", error, 1'b0);
    chk1("len65_reload_in_ready", in_ready, 1'b1);

    w.delete();
    load(0, w, 8'h00);
    chk1("n0_done", done, 1'b1);
    chk("n0_writes", wr_cnt - base, 32'd0);
    reload_pulse(1'b0);

    base = wr_cnt;
    load(64, rand_words(64), 8'h00);
    chk("n64_writes", wr_cnt - base, 32'd64);
    chk1("n64_done", done, 1'b1);
    reload_pulse(1'b0);

    bp = 1'b0;
    send(8'h02); send(8'h00);
    w = rand_words(2);
    for (int j = 0; j < 4; j++) send(w[0][8*j +: 8]);
    for (int j = 0; j < 3; j++) send(w[1][8*j +: 8]);
    base = wr_cnt;
    @(negedge CLK);
    in_valid = 1'b0; RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    chk("mid_rst_waddr", {26'd0, mem_waddr}, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    idle(3);
    chk("mid_rst_no_w1", wr_cnt, base);
    w.delete(); w.push_back(32'h00000013);
    load(1, w, 8'h00);
    chk("fresh_addr0", dut_mem[0], 32'h00000013);
    chk("fresh_waddr", {26'd0, mem_waddr}, 32'd0);
    chk1("fresh_done", done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    reload_pulse(1'b0);
    load(1, w, 8'h00);
    chk1("csum14_done", done, 1'b1);
    reload_pulse(1'b0);
    load(1, w, 8'h01);
    chk1("csum15_error", error, 1'b1);
    chk1("csum15_core_rst_n", core_rst_n, 1'b0);
`endif

    bp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reload_pulse(1'($urandom));
      n = $urandom_range(1, 8);
      load(n, rand_words(n), CS ? 8'($urandom_range(0, 1)) : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
